// File: rtl/program_loader_pkg.sv
// Shared CPU package: loader state encoding plus instruction-format and
// memory-map constants used by the loader, the fetch logic and the
// instruction memory.
package program_loader_pkg;

  // Instruction word: 6 opcode, 4 rs, 4 rt, 4 rd, 16 imm
  localparam int INSTR_W   = 34;
  localparam int BASE_ADDR = 4096;
  localparam int STRIDE    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader: accepts a program as a valid/ready word stream and writes
// it into instruction memory, holding the CPU in reset until the final write
// has landed.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - single-cycle pulse beginning a load (ignored in LOAD/DRAIN)
//   s_valid    - upstream word valid
//   s_ready    - loader accepts a word (registered, high only in LOAD)
//   s_data     - instruction word
//   s_last     - final word of the program
//   imem_we    - instruction memory write strobe (one cycle per accepted word)
//   imem_addr  - write address, BASE_ADDR + STRIDE*index
//   imem_wdata - write data
//   cpu_reset  - active-high CPU hold, low only in RUN
//   done       - program loaded and CPU running
//   error      - more than MAX_WORDS words offered without s_last
//   word_count - words accepted in the current load
module program_loader #(
  parameter int INSTR_W   = program_loader_pkg::INSTR_W,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = program_loader_pkg::BASE_ADDR,
  parameter int STRIDE    = program_loader_pkg::STRIDE,
  parameter int MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_data,
  input  logic               s_last,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               done,
  output logic               error,
  output logic [8:0]         word_count
);
  import program_loader_pkg::*;

  localparam int WC_W = 9;

  loader_state_t state, state_nxt;
  logic          xfer;
  logic          at_limit;

  // Address arithmetic done at 32 bits, then truncated to the memory width.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [WC_W-1:0] idx);
    logic [31:0] full;
    full = 32'(BASE_ADDR) + 32'(STRIDE) * 32'(idx);
    return full[ADDR_W-1:0];
  endfunction

  // s_ready is only ever high in LOAD, so the state term is redundant in
  // normal operation; it keeps a stray s_ready from leaking a transfer.
  assign xfer     = s_valid && s_ready && (state == ST_LOAD);
  assign at_limit = (word_count == WC_W'(MAX_WORDS));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // Overflow takes priority over s_last: the 257th word is never written.
        if (xfer) begin
          if (at_limit)    state_nxt = ST_ERR;
          else if (s_last) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with
  // the state they describe (s_ready is high in the first LOAD cycle,
  // cpu_reset rises the cycle after start, and falls on entry to RUN).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == ST_LOAD);
      cpu_reset <= (state_nxt != ST_RUN);
      done      <= (state_nxt == ST_RUN);
      error     <= (state_nxt == ST_ERR);
      if ((state_nxt == ST_LOAD) && (state != ST_LOAD))
        word_count <= '0;
      else if (xfer && !at_limit)
        word_count <= word_count + WC_W'(1);
    end
  end

  // Write stage: one accepted word becomes a single-cycle imem write.
  // Reset clears the strobe, dropping any write still pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= xfer && !at_limit;
      if (xfer && !at_limit) begin
        imem_addr  <= word_addr(word_count);
        imem_wdata <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a table-driven cycle check of the reference
// four-instruction program, hand-written sequences for stalls, restarts,
// reset and overflow, and randomised loads checked against a list-level model.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int AW   = 16;
  localparam int MAXW = 256;

  logic               clk = 1'b0;
  logic               reset, start, s_valid, s_ready, s_last;
  logic [INSTR_W-1:0] s_data, imem_wdata;
  logic               imem_we, cpu_reset, done, error;
  logic [AW-1:0]      imem_addr;
  logic [8:0]         word_count;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every write strobe is captured once, mid-cycle.
  typedef struct { logic [AW-1:0] addr; logic [INSTR_W-1:0] data; } wr_t;
  wr_t wr_q[$];
  always @(negedge clk) begin : mon
    wr_t w;
    if (reset === 1'b1 && imem_we === 1'b1) begin
      w.addr = imem_addr;
      w.data = imem_wdata;
      wr_q.push_back(w);
    end
  end

  logic [INSTR_W-1:0] words[$];
  logic [INSTR_W-1:0] prog[4];

  function automatic logic [INSTR_W-1:0] rand_word();
    return {2'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [INSTR_W-1:0] enc(input logic [5:0] op, input logic [3:0] rs,
                                             input logic [3:0] rt, input logic [3:0] rd,
                                             input logic [15:0] imm);
    return {op, rs, rt, rd, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer words[first..stop-1], with random idle gaps carrying junk data.
  task automatic feed(input int first, input int stop, input bit with_last, input int gapmax);
    int g;
    for (int i = first; i < stop; i++) begin
      g = $urandom_range(gapmax, 0);
      repeat (g) begin
        s_valid = 1'b0;
        s_data  = rand_word();
        s_last  = 1'($urandom);
        tick();
      end
      s_valid = 1'b1;
      s_data  = words[i];
      s_last  = with_last && (i == stop - 1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Model: the first min(n, MAXW) words land at consecutive word addresses;
  // a terminated load ends running, an over-long one ends in error.
  task automatic check_load(input string tag, input int n, input bit with_last);
    int nw;
    logic [31:0] a;
    nw = (n > MAXW) ? MAXW : n;
    check({tag, "_nwrites"}, wr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_q.size(); i++) begin
      a = BASE_ADDR + STRIDE * i;
      check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, a[AW-1:0]);
      check($sformatf("%s_data%0d", tag, i), wr_q[i].data, words[i]);
    end
    if (n > MAXW) begin
      check({tag, "_error"}, error, 1);
      check({tag, "_cpu_reset"}, cpu_reset, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_ready"}, s_ready, 0);
    end else if (with_last) begin
      check({tag, "_count"}, word_count, n);
      check({tag, "_error"}, error, 0);
      check({tag, "_cpu_reset"}, cpu_reset, 0);
      check({tag, "_done"}, done, 1);
      check({tag, "_ready"}, s_ready, 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, s_ready, 0);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_count"}, word_count, 0);
  endtask

  // Tiny CPU interpreter over the captured image: LW / ADD / SW.
  task automatic run_cpu_check();
    logic [INSTR_W-1:0] imem[int];
    int dmem[int];
    int regs[16];
    int pc;
    logic [INSTR_W-1:0] ins;
    int addr;
    foreach (wr_q[i]) imem[int'(wr_q[i].addr)] = wr_q[i].data;
    foreach (regs[i]) regs[i] = 0;
    dmem[0] = 20;
    dmem[4] = 22;
    pc = BASE_ADDR;
    while (imem.exists(pc) && pc < BASE_ADDR + 64) begin
      ins  = imem[pc];
      addr = regs[ins[27:24]] + int'(ins[15:0]);
      case (ins[33:28])
        6'h23: regs[ins[23:20]] = dmem.exists(addr) ? dmem[addr] : 0;
        6'h2B: dmem[addr] = regs[ins[23:20]];
        6'h00: regs[ins[19:16]] = regs[ins[27:24]] + regs[ins[23:20]];
        default: ;
      endcase
      pc += STRIDE;
    end
    check("cpu_store48", dmem.exists(48) ? dmem[48] : -1, 42);
  endtask

  typedef struct {
    logic       st, vl, la;
    int         widx;
    logic       rdy, we;
    logic [15:0] addr;
    logic       crst, dn;
    logic [8:0] cnt;
  } vec_t;
  vec_t tbl[7];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    prog[0] = enc(6'h23, 4'd0, 4'd1, 4'd0, 16'd0);   // LW  r1, 0(r0)
    prog[1] = enc(6'h23, 4'd0, 4'd2, 4'd0, 16'd4);   // LW  r2, 4(r0)
    prog[2] = enc(6'h00, 4'd1, 4'd2, 4'd3, 16'd0);   // ADD r3, r1, r2
    prog[3] = enc(6'h2B, 4'd0, 4'd3, 4'd0, 16'd48);  // SW  r3, 48(r0)

    //         st vl la widx  rdy we addr  crst dn cnt
    tbl[0] = '{1, 0, 0, -1,   1,  0, 0,    1,   0, 0};
    tbl[1] = '{0, 1, 0,  0,   1,  1, 4096, 1,   0, 1};
    tbl[2] = '{0, 1, 0,  1,   1,  1, 4100, 1,   0, 2};
    tbl[3] = '{0, 1, 0,  2,   1,  1, 4104, 1,   0, 3};
    tbl[4] = '{0, 1, 1,  3,   0,  1, 4108, 1,   0, 4};
    tbl[5] = '{0, 0, 0, -1,   0,  0, 0,    0,   1, 4};
    tbl[6] = '{0, 0, 0, -1,   0,  0, 0,    0,   1, 4};

    reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("idle_cpu_reset", cpu_reset, 1);
    check("idle_ready", s_ready, 0);

    // Reference program, back-to-back, cycle by cycle
    wr_q.delete();
    for (int r = 0; r < 7; r++) begin
      start   = tbl[r].st;
      s_valid = tbl[r].vl;
      s_last  = tbl[r].la;
      s_data  = (tbl[r].widx >= 0) ? prog[tbl[r].widx] : rand_word();
      tick();
      start = 1'b0;
      check($sformatf("tbl%0d_ready", r), s_ready, tbl[r].rdy);
      check($sformatf("tbl%0d_we", r), imem_we, tbl[r].we);
      check($sformatf("tbl%0d_cpu_reset", r), cpu_reset, tbl[r].crst);
      check($sformatf("tbl%0d_done", r), done, tbl[r].dn);
      check($sformatf("tbl%0d_count", r), word_count, tbl[r].cnt);
      check($sformatf("tbl%0d_error", r), error, 0);
      if (tbl[r].we) begin
        check($sformatf("tbl%0d_addr", r), imem_addr, tbl[r].addr);
        check($sformatf("tbl%0d_wdata", r), imem_wdata, prog[tbl[r].widx]);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("tbl_nwrites", wr_q.size(), 4);
    run_cpu_check();

    // Same program with a 3-cycle valid gap between words 2 and 3
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back(prog[i]);
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        repeat (3) begin
          s_valid = 1'b0; s_data = rand_word(); s_last = 1'b1; tick();
        end
      end
      s_valid = 1'b1; s_data = words[i]; s_last = (i == 3); tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    check_load("stall", 4, 1);
    run_cpu_check();

    // Restart from RUN with a one-word program
    words.delete();
    words.push_back(rand_word());
    wr_q.delete();
    pulse_start();
    check("rerun_cpu_reset", cpu_reset, 1);
    check("rerun_done", done, 0);
    check("rerun_ready", s_ready, 1);
    check("rerun_count", word_count, 0);
    feed(0, 1, 1, 0);
    check("rerun_drain_done", done, 0);
    check("rerun_drain_cpu_reset", cpu_reset, 1);
    tick();
    check_load("rerun", 1, 1);

    // start pulsed mid-load is ignored
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back(rand_word());
    wr_q.delete();
    pulse_start();
    feed(0, 2, 0, 1);
    start = 1'b1; s_valid = 1'b0; tick(); start = 1'b0;
    check("midstart_count", word_count, 2);
    check("midstart_ready", s_ready, 1);
    check("midstart_cpu_reset", cpu_reset, 1);
    feed(2, 5, 1, 1);
    tick();
    check_load("midstart", 5, 1);

    // Reset asserted right after word 2's transfer edge
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(rand_word());
    pulse_start();
    s_valid = 1'b1; s_data = words[0]; tick();
    s_data = words[1];
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    wr_q.delete();
    pulse_start();
    feed(0, 1, 1, 0);
    tick();
    check_load("postreset", 1, 1);

    // 257 words with no last: overflow
    words.delete();
    for (int i = 0; i < 257; i++) words.push_back(rand_word());
    wr_q.delete();
    pulse_start();
    feed(0, 257, 0, 0);
    tick();
    check_load("ovf", 257, 0);
    if (wr_q.size() == MAXW) check("ovf_last_addr", wr_q[MAXW-1].addr, 5116);
    repeat (3) tick();
    check("ovf_hold_error", error, 1);
    check("ovf_hold_we", imem_we, 0);

    // Leave ERR with start
    pulse_start();
    check("errexit_error", error, 0);
    check("errexit_ready", s_ready, 1);
    check("errexit_count", word_count, 0);
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(rand_word());
    wr_q.delete();
    feed(0, 3, 1, 2);
    tick();
    check_load("errexit", 3, 1);

    // Exactly MAX_WORDS with last on the final word
    words.delete();
    for (int i = 0; i < MAXW; i++) words.push_back(rand_word());
    wr_q.delete();
    pulse_start();
    feed(0, MAXW, 1, 0);
    tick();
    check_load("full", MAXW, 1);

    // Randomised loads with random gaps
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(24, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(rand_word());
      wr_q.delete();
      pulse_start();
      feed(0, n, 1, 3);
      tick();
      check_load($sformatf("rnd%0d", t), n, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
